// File: rtl/clk_div_sched_if.sv
// Configuration / control / status bundle for clk_div_sched.
//   master : command front end (offers config, start/stop, observes status)
//   slave  : clk_div_sched itself
// Signals: cfg_valid/cfg_ready/cfg_div/cfg_burst/cfg_err config handshake,
//          start/stop run control, busy/clk_div_out/cnt_out/period_done/
//          run_done divider status.
interface clk_div_sched_if #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               busy;
  logic               clk_div_out;
  logic [CNT_W-1:0]   cnt_out;
  logic               period_done;
  logic               run_done;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, cfg_err, busy, clk_div_out, cnt_out, period_done, run_done
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, cfg_err, busy, clk_div_out, cnt_out, period_done, run_done
  );
endinterface

// File: rtl/clk_div_sched.sv
// Run-time controller for the programmable clock divider.
// Holds the active divide ratio plus a one-deep shadow config, and runs the
// divide counter continuously (burst=0) or for a fixed number of periods.
// Ratio changes take effect only at a period boundary so clk_div_out never
// produces a runt pulse.
// Ports:
//   clk        system clock
//   phase_rst  asynchronous active-high reset
//   bus        clk_div_sched_if.slave (config handshake, run control, status)
module clk_div_sched #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 1000,
  parameter int BURST_W     = 16
) (
  input logic            clk,
  input logic            phase_rst,
  clk_div_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   div_act, div_nxt;
  logic [BURST_W-1:0] burst_act, burst_nxt;
  logic [BURST_W-1:0] run_burst, run_burst_nxt;
  logic [CNT_W-1:0]   sh_div, sh_div_nxt;
  logic [BURST_W-1:0] sh_burst, sh_burst_nxt;
  logic               sh_full, sh_full_nxt;
  logic [BURST_W-1:0] pcnt, pcnt_nxt, pcnt_inc;
  logic               clk_q, clk_nxt;
  logic               pd_q, pd_nxt;
  logic               rd_q, rd_nxt;
  logic               err_q, err_nxt;
  logic               xfer, boundary;
  logic [CNT_W-1:0]   div_m1_nxt;

  assign xfer     = bus.cfg_valid && !sh_full;
  assign boundary = (cnt == div_act - 1'b1);

  always_ff @(posedge clk or posedge phase_rst) begin
    if (phase_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      div_act   <= DEF_DIV;
      burst_act <= '0;
      run_burst <= '0;
      sh_div    <= '0;
      sh_burst  <= '0;
      sh_full   <= 1'b0;
      pcnt      <= '0;
      clk_q     <= 1'b1;
      pd_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div_act   <= div_nxt;
      burst_act <= burst_nxt;
      run_burst <= run_burst_nxt;
      sh_div    <= sh_div_nxt;
      sh_burst  <= sh_burst_nxt;
      sh_full   <= sh_full_nxt;
      pcnt      <= pcnt_nxt;
      clk_q     <= clk_nxt;
      pd_q      <= pd_nxt;
      rd_q      <= rd_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    div_nxt       = div_act;
    burst_nxt     = burst_act;
    run_burst_nxt = run_burst;
    sh_div_nxt    = sh_div;
    sh_burst_nxt  = sh_burst;
    sh_full_nxt   = sh_full;
    pcnt_nxt      = pcnt;
    pcnt_inc      = pcnt + 1'b1;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // A shadow written on the very edge we fell into IDLE is applied here.
        if (sh_full) begin
          div_nxt     = sh_div;
          burst_nxt   = sh_burst;
          sh_full_nxt = 1'b0;
        end
        if (bus.start) begin
          state_nxt     = RUN;
          run_burst_nxt = sh_full ? sh_burst : burst_act;
          pcnt_nxt      = '0;
        end
      end
      RUN, DRAIN: begin
        if (boundary) begin
          cnt_nxt  = '0;
          pcnt_nxt = pcnt_inc;
          if (sh_full) begin
            div_nxt     = sh_div;
            burst_nxt   = sh_burst;
            sh_full_nxt = 1'b0;
          end
          // stop seen exactly at a boundary ends the run right here.
          if (state == DRAIN || bus.stop ||
              (run_burst != '0 && pcnt_inc == run_burst))
            state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (state == RUN && bus.stop) state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // cfg_ready is !sh_full, so a transfer never collides with a shadow copy.
    if (xfer) begin
      if (bus.cfg_div < CNT_W'(2)) begin
        err_nxt = 1'b1;
      end else if (state == IDLE) begin
        div_nxt   = bus.cfg_div;
        burst_nxt = bus.cfg_burst;
      end else begin
        sh_div_nxt   = bus.cfg_div;
        sh_burst_nxt = bus.cfg_burst;
        sh_full_nxt  = 1'b1;
      end
    end

    // Waveform/status are computed from next-state values so the registered
    // outputs line up with cnt_out, including across a ratio change.
    div_m1_nxt = div_nxt - 1'b1;
    clk_nxt    = (state_nxt == IDLE) || (cnt_nxt <= (div_m1_nxt >> 1));
    pd_nxt     = (state_nxt != IDLE) && (cnt_nxt == div_m1_nxt);
    rd_nxt     = (state != IDLE) && (state_nxt == IDLE);
  end

  assign bus.cfg_ready   = !sh_full;
  assign bus.cfg_err     = err_q;
  assign bus.busy        = (state != IDLE);
  assign bus.clk_div_out = clk_q;
  assign bus.cnt_out     = cnt;
  assign bus.period_done = pd_q;
  assign bus.run_done    = rd_q;

endmodule

// File: tb/tb_clk_div_sched.sv
module tb_clk_div_sched;
  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  logic clk = 1'b0;
  logic phase_rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_sched_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(1000), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .phase_rst (phase_rst),
    .bus       (bus)
  );

  typedef struct {
    logic               v;
    logic [CNT_W-1:0]   d;
    logic [BURST_W-1:0] b;
    logic               st;
    logic               sp;
    int                 n;      // extra idle cycles after the 1-cycle drive
    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic               ck;
    logic               pd;
    logic               rdy;
    logic               err;
    logic               rd;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   bad     = 0;

  function automatic vec_t mk(logic v, int d, int b, logic st, logic sp, int n,
                              logic busy, int cnt, logic ck, logic pd,
                              logic rdy, logic err, logic rd);
    vec_t r;
    r.v = v; r.d = CNT_W'(d); r.b = BURST_W'(b); r.st = st; r.sp = sp; r.n = n;
    r.busy = busy; r.cnt = CNT_W'(cnt); r.ck = ck; r.pd = pd;
    r.rdy = rdy; r.err = err; r.rd = rd;
    return r;
  endfunction

  task automatic check(string name, logic busy, logic [CNT_W-1:0] cnt,
                       logic ck, logic pd, logic rdy, logic err, logic rd);
    applied++;
    if (bus.busy !== busy || bus.cnt_out !== cnt || bus.clk_div_out !== ck ||
        bus.period_done !== pd || bus.cfg_ready !== rdy ||
        bus.cfg_err !== err || bus.run_done !== rd) begin
      bad++;
      $display("FAIL %s got busy=%b cnt=%0d clk=%b pd=%b rdy=%b err=%b rd=%b want busy=%b cnt=%0d clk=%b pd=%b rdy=%b err=%b rd=%b",
               name, bus.busy, bus.cnt_out, bus.clk_div_out, bus.period_done,
               bus.cfg_ready, bus.cfg_err, bus.run_done,
               busy, cnt, ck, pd, rdy, err, rd);
    end
  endtask

  task automatic check_val(string name, int got, int want);
    applied++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int hi, pdc;
    bus.cfg_valid = 0; bus.cfg_div = '0; bus.cfg_burst = '0;
    bus.start = 0; bus.stop = 0;

    //        v  div burst st sp n  busy cnt clk pd rdy err rd
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // reset state
    tbl.push_back(mk(1, 3, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // idle cfg -> active
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0)); // start
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 1, 0, 0)); // div3 low phase
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 1, 2, 0, 1, 1, 0, 0)); // cycle 12
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1)); // burst done
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)); // run_done 1 cycle
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0)); // div<2 -> err
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0)); // shadow at cnt3
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 9, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0)); // div4 applied
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0)); // div8 applied
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 3, 1, 0, 1, 0, 0)); // stop -> drain
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 7, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1)); // drained
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0)); // start wins
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 4, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0)); // shadow pending

    repeat (2) @(negedge clk);
    phase_rst = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.cfg_valid = tbl[i].v; bus.cfg_div = tbl[i].d; bus.cfg_burst = tbl[i].b;
      bus.start = tbl[i].st; bus.stop = tbl[i].sp;
      @(negedge clk);
      bus.cfg_valid = 0; bus.start = 0; bus.stop = 0;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].busy, tbl[i].cnt, tbl[i].ck,
            tbl[i].pd, tbl[i].rdy, tbl[i].err, tbl[i].rd);
    end

    // Asynchronous reset between edges, mid-run with a pending shadow.
    #2 phase_rst = 1;
    #1 check("async_rst", 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    phase_rst = 0;

    // Default ratio 1000, continuous: 500 high / 500 low, one period_done.
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    hi = 0; pdc = 0;
    for (int i = 0; i < 1000; i++) begin
      hi += int'(bus.clk_div_out);
      pdc += int'(bus.period_done);
      @(negedge clk);
    end
    check_val("default_high", hi, 500);
    check_val("default_pd", pdc, 1);
    check("default_wrap", 1, 0, 1, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Run-time controller for the programmable clock-divider datapath. It holds the active divide ratio and a one-deep shadow configuration, and runs the divide counter continuously or for a fixed number of periods. New ratios are applied only at a period boundary, so clk_div_out never produces a runt pulse. The block sits between the register/command front end and the divided-clock consumers (ADC/DAC strobes, sample ticks).

Parameters:
CNT_W, 32, width of divide ratio and counter
DEFAULT_DIV, 1000, active ratio after reset (must be >= 2)
BURST_W, 16, width of burst period count

Ports:
clk  in  1  system clock
phase_rst  in  1  reset, asynchronous, active-high; clock clk
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration can be accepted
cfg_div  in  CNT_W  requested divide ratio
cfg_burst  in  BURST_W  periods per run; 0 = continuous
cfg_err  out  1  1-cycle pulse: offered cfg_div < 2, rejected
start  in  1  begin a run (level sampled each clk)
stop  in  1  end run at next period boundary
busy  out  1  state is RUN or DRAIN
clk_div_out  out  1  divided clock
cnt_out  out  CNT_W  phase counter, 0..div-1
period_done  out  1  high in the cycle cnt_out == div-1 while busy
run_done  out  1  1-cycle pulse on return to IDLE

Behaviour:
- phase_rst (any time, including mid-run): state IDLE; cnt_out=0; clk_div_out=1; active div=DEFAULT_DIV; active burst=0; shadow empty; cfg_ready=1; cfg_err, period_done, run_done=0; period counter=0.
- All outputs are registered. period_done is registered and aligned with cnt_out.
- Handshake: a transfer occurs when cfg_valid && cfg_ready on a rising clk.
  - cfg_ready = !shadow_full.
  - If cfg_div < 2: the transfer completes, cfg_err pulses the next cycle, and nothing is stored.
  - Otherwise: in IDLE the config is written directly to the active registers, so the shadow stays empty. In RUN or DRAIN it is written to the shadow and shadow_full is set.
- States:
  - IDLE: cnt_out=0, clk_div_out=1.
    - start=1 -> RUN. Latch active burst, clear the period counter.
    - cnt_out starts counting from 0 on the following cycle.
    - stop is ignored; start and stop asserted together -> start wins.
  - RUN: cnt increments each cycle and wraps at div-1.
    - With h = (div-1)>>1, clk_div_out=1 for cnt 0..h and 0 for cnt h+1..div-1.
    - Example: div=1000 gives 500 high / 500 low; div=3 gives 2 high / 1 low.
    - At cnt==div-1 (boundary): the period counter increments. If shadow_full, shadow -> active div and shadow_full clears.
    - If burst != 0 and the incremented count == burst -> IDLE.
    - stop=1 -> DRAIN, with no change to the counter.
    - start is ignored.
  - DRAIN: counts exactly as RUN. At cnt==div-1 -> IDLE.
- Entering IDLE: run_done pulses for 1 cycle; cnt_out=0; clk_div_out=1. A pending shadow is copied to active div.
- Burst value is taken from the active config only at start. A shadow burst affects the next run only.
- Simultaneous boundary and handshake, shadow empty: the incoming config goes to the shadow and is not applied until the next boundary.
- cnt arithmetic is CNT_W wide, unsigned. div-1 never underflows because div >= 2 is guaranteed.

Test Plan:
- Reset, then start with default div=1000, burst=0 -> clk_div_out high 500 / low 500 cycles; period_done every 1000 cycles; busy=1.
- In IDLE, cfg div=3 burst=4, then start -> exactly 4 periods (2 high / 1 low); run_done pulses at the end of cycle 12; busy drops; cnt_out=0.
- Running at div=10: cfg div=4 accepted at cnt=3 -> cfg_ready=0 until the cnt==9 boundary; next period is 4 cycles; cfg_ready returns to 1.
- cfg_div=1 offered -> cfg_err pulses once, active div unchanged, waveform unaffected.
- Running at div=8: stop at cnt=2 -> remaining cycles 3..7 complete, then IDLE with run_done; start+stop together in IDLE -> run starts.
- phase_rst asserted mid-run at cnt=5 (async, between clk edges) -> outputs immediately return to reset values, shadow is cleared, div=1000.
